// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache in front of Fetch.
//   Hits return Instruct combinationally in the same cycle. A miss raises
//   FetchStall and refills the whole line over a MemReq/MemAck handshake,
//   one word per acknowledged edge, followed by one DONE cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   Addr[15:0]        word fetch address from Fetch
//   Stall             pipeline stall (gates hit counting only)
//   Invalidate        one-cycle pulse clearing all valid bits
//   Instruct[15:0]    hit data, 0 when not hitting
//   FetchStall        1 = Instruct not valid, Fetch holds its PC
//   MemReq, MemAddr   fill request and word address to backing memory
//   MemAck, MemData   fill word handshake and data from backing memory
// Optional: define ICACHE_STATS_EN to add saturating HitCount/MissCount outputs.
module icache_direct #(
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned TAG_BITS    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic        Stall,
  input  logic        Invalidate,
  output logic [15:0] Instruct,
  output logic        FetchStall,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  input  logic        MemAck,
  input  logic [15:0] MemData
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] HitCount,
  output logic [15:0] MissCount
`endif
);

  localparam int unsigned LINE_BITS = 16 - OFFSET_BITS;
  localparam int unsigned LINES     = 1 << INDEX_BITS;
  localparam int unsigned WORDS     = 1 << (INDEX_BITS + OFFSET_BITS);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                   state_q, state_d;
  logic [LINE_BITS-1:0]     miss_line_q, miss_line_d;
  logic [OFFSET_BITS-1:0]   fill_cnt_q, fill_cnt_d;
  logic                     poison_q, poison_d;
  logic [LINES-1:0]         valid_q;
  logic [TAG_BITS-1:0]      tag_q  [LINES];
  logic [15:0]              data_q [WORDS];

  logic [TAG_BITS-1:0]      tag;
  logic [INDEX_BITS-1:0]    index;
  logic [INDEX_BITS-1:0]    miss_index;
  logic                     hit;
  logic                     fill_we;
  logic                     fill_last;

  assign tag        = Addr[15 -: TAG_BITS];
  assign index      = Addr[OFFSET_BITS +: INDEX_BITS];
  assign miss_index = miss_line_q[INDEX_BITS-1:0];

  assign hit        = valid_q[index] && (tag_q[index] == tag) && (state_q == IDLE);
  assign Instruct   = hit ? data_q[Addr[INDEX_BITS+OFFSET_BITS-1:0]] : '0;
  assign FetchStall = ~hit & ~rst;
  assign MemReq     = (state_q == FILL);
  assign MemAddr    = (state_q == FILL) ? {miss_line_q, fill_cnt_q} : '0;

  always_comb begin
    state_d     = state_q;
    miss_line_d = miss_line_q;
    fill_cnt_d  = fill_cnt_q;
    poison_d    = poison_q;
    fill_we     = 1'b0;
    fill_last   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!hit) begin
          miss_line_d = Addr[15:OFFSET_BITS];
          fill_cnt_d  = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (Invalidate) poison_d = 1'b1;
        if (MemAck) begin
          fill_we = 1'b1;
          if (fill_cnt_q == '1) begin
            fill_last = 1'b1;
            state_d   = DONE;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // An Invalidate here already clears valid bits directly; poison
        // would be dropped on the return to IDLE anyway.
        poison_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_line_q <= '0;
      fill_cnt_q  <= '0;
      poison_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
      fill_cnt_q  <= fill_cnt_d;
      poison_q    <= poison_d;
    end
  end

  // Invalidate wins over the final fill beat, so a line whose fill overlaps
  // an invalidate (now or earlier, via poison) is never marked valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (Invalidate) begin
      valid_q <= '0;
    end else if (fill_last && !poison_q) begin
      valid_q[miss_index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[{miss_index, fill_cnt_q}] <= MemData;
      if (fill_last) tag_q[miss_index] <= miss_line_q[LINE_BITS-1 -: TAG_BITS];
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      if (hit && !Stall && HitCount != '1) HitCount <= HitCount + 1'b1;
      if (state_q == IDLE && state_d == FILL && MissCount != '1)
        MissCount <= MissCount + 1'b1;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = Stall;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: memory model returns addr ^ 16'hA5A5.
module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic [15:0] Addr;
  logic        Stall;
  logic        Invalidate;
  logic [15:0] Instruct;
  logic        FetchStall;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic        MemAck;
  logic [15:0] MemData;
`ifdef ICACHE_STATS_EN
  logic [15:0] HitCount;
  logic [15:0] MissCount;
`endif

  int checks;
  int failures;
  int stalls;
  int naddr;
  logic [15:0] addrs [8];

  icache_direct dut (
    .clk        (clk),
    .rst        (rst),
    .Addr       (Addr),
    .Stall      (Stall),
    .Invalidate (Invalidate),
    .Instruct   (Instruct),
    .FetchStall (FetchStall),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemAck     (MemAck),
    .MemData    (MemData)
`ifdef ICACHE_STATS_EN
    ,
    .HitCount   (HitCount),
    .MissCount  (MissCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents address a and services fills until FetchStall drops (bounded).
  // MemAck is withheld on fill cycles [hold_at, hold_at+hold_len); Invalidate
  // pulses on fill cycle inv_at. Fill cycles are counted across refills.
  task automatic run_miss(input logic [15:0] a, input int hold_at, input int hold_len,
                          input int inv_at);
    int fc;
    bit hold;
    fc     = 0;
    stalls = 0;
    naddr  = 0;
    Addr   = a;
    #1;
    while (FetchStall && stalls < 100) begin
      if (MemReq) begin
        hold       = (fc >= hold_at) && (fc < hold_at + hold_len);
        MemAck     = !hold;
        MemData    = MemAddr ^ 16'hA5A5;
        Invalidate = (fc == inv_at);
        if (!hold && naddr < 8) begin
          addrs[naddr] = MemAddr;
          naddr++;
        end
        fc++;
      end else begin
        MemAck     = 1'b0;
        Invalidate = 1'b0;
      end
      stalls++;
      tick();
    end
    MemAck     = 1'b0;
    Invalidate = 1'b0;
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    Addr       = 16'h0000;
    Stall      = 1'b0;
    Invalidate = 1'b0;
    MemAck     = 1'b0;
    MemData    = 16'h0000;
    #1;
    chk("rst_fetchstall", {31'd0, FetchStall}, 32'd0);
    chk("rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("rst_memaddr", {16'd0, MemAddr}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("cold_miss", {31'd0, FetchStall}, 32'd1);
    chk("cold_idle_noreq", {31'd0, MemReq}, 32'd0);

    // T1: cold miss on line 0
    run_miss(16'h0000, 99, 0, 99);
    chk("t1_stalls", stalls, 32'd6);
    chk("t1_nbeats", naddr, 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_memaddr", {16'd0, addrs[i]}, i);
    chk("t1_instr", {16'd0, Instruct}, 32'h0000A5A5);
    chk("t1_fetchstall", {31'd0, FetchStall}, 32'd0);
    tick();

    // T2: hits on the rest of line 0
    Addr = 16'h0001; #1;
    chk("t2_instr1", {16'd0, Instruct}, 32'h0000A5A4);
    chk("t2_stall1", {30'd0, FetchStall, MemReq}, 32'd0);
    tick();
    Addr = 16'h0002; #1;
    chk("t2_instr2", {16'd0, Instruct}, 32'h0000A5A7);
    chk("t2_stall2", {30'd0, FetchStall, MemReq}, 32'd0);
    tick();
    Addr = 16'h0003; #1;
    chk("t2_instr3", {16'd0, Instruct}, 32'h0000A5A6);
    chk("t2_stall3", {30'd0, FetchStall, MemReq}, 32'd0);
    tick();
`ifdef ICACHE_STATS_EN
    chk("stats_hits", {16'd0, HitCount}, 32'd4);
    chk("stats_misses", {16'd0, MissCount}, 32'd1);
`endif

    // T3: conflicting tag on index 0
    run_miss(16'h0040, 99, 0, 99);
    chk("t3_stalls", stalls, 32'd6);
    chk("t3_first_addr", {16'd0, addrs[0]}, 32'h00000040);
    chk("t3_instr", {16'd0, Instruct}, 32'h0000A5E5);
    tick();
    Addr = 16'h0000; #1;
    chk("t3_evicted", {31'd0, FetchStall}, 32'd1);

    // T4: MemAck withheld 3 cycles mid-fill
    run_miss(16'h0000, 2, 3, 99);
    chk("t4_stalls", stalls, 32'd9);
    chk("t4_beat2", {16'd0, addrs[2]}, 32'd2);
    chk("t4_beat3", {16'd0, addrs[3]}, 32'd3);
    chk("t4_instr", {16'd0, Instruct}, 32'h0000A5A5);
    tick();

    // T5: Invalidate during fill poisons the line, so it refills once more
    run_miss(16'h0004, 99, 0, 1);
    chk("t5_poison_stalls", stalls, 32'd12);
    chk("t5_instr", {16'd0, Instruct}, 32'h0000A5A1);
    tick();
    Addr = 16'h0000; #1;
    chk("t5_line0_cleared", {31'd0, FetchStall}, 32'd1);
    run_miss(16'h0000, 99, 0, 99);
    chk("t5_refill_stalls", stalls, 32'd6);
    Invalidate = 1'b1;
    tick();
    Invalidate = 1'b0;
    #1;
    chk("t5_idle_inval", {31'd0, FetchStall}, 32'd1);
    run_miss(16'h0008, 99, 0, 3);
    chk("t5_final_ack_inval", stalls, 32'd12);
    chk("t5_instr8", {16'd0, Instruct}, 32'h0000A5AD);
    tick();

    // T6: reset during fill
    Addr = 16'h0000; #1;
    tick();
    chk("t6_inflight", {31'd0, MemReq}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("t6_rst_memaddr", {16'd0, MemAddr}, 32'd0);
    chk("t6_rst_fetchstall", {31'd0, FetchStall}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_post_miss", {31'd0, FetchStall}, 32'd1);
    chk("t6_post_noreq", {31'd0, MemReq}, 32'd0);
    run_miss(16'h0000, 99, 0, 99);
    chk("t6_stalls", stalls, 32'd6);
    chk("t6_instr", {16'd0, Instruct}, 32'h0000A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
